crossbar_grant_ctrl: RTL and testbench
======================================

# crossbar_grant_ctrl

Per-egress-port request collector and grant holder for the switch-core crossbar; sits directly upstream of the 10-way round-robin arbiter. Each cycle it samples 10 ingress request lines, issues one single-cycle arbitration request, latches the one-hot grant, and holds the crossbar connection until the granted packet's last beat is accepted downstream. A watchdog releases stuck grants, and malformed grants are rejected.

## Interface
- `DATA_W`, 8: per-port beat width in bits.
- `TIMEOUT_CYC`, 1024: maximum idle cycles in a transfer before the grant is forcibly released.
- `ARB_WAIT_CYC`, 4: maximum cycles to wait for the arbiter result.

Ports:
- `i_sys_clk`  in  1  system clock; the single clock domain.
- `i_sys_rst_n`  in  1  synchronous, active-low reset.
- `i_port_req`  in  10  per-ingress request for this egress port.
- `i_port_data`  in  10*DATA_W  ingress beats; port k occupies bits [k*DATA_W +: DATA_W].
- `i_port_valid`  in  10  per-ingress beat valid.
- `i_port_last`  in  10  per-ingress last-beat flag.
- `o_port_ready`  out  10  per-ingress ready.
- `o_egr_data`  out  DATA_W  egress beat.
- `o_egr_valid`  out  1  egress valid.
- `o_egr_last`  out  1  egress last.
- `i_egr_ready`  in  1  egress ready.
- `o_arb_data`  out  10  request snapshot sent to the arbiter.
- `o_arb_valid`  out  1  arbitration request pulse.
- `i_arb_result`  in  10  arbiter grant.
- `i_arb_valid`  in  1  arbiter result valid.
- `o_grant`  out  10  registered current grant.
- `o_busy`  out  1  high when the state is not IDLE.
- `o_timeout`  out  1  one-cycle pulse on watchdog release.
- `o_grant_err`  out  1  one-cycle pulse on a zero or multi-hot grant.

## Operation
- FSM states: IDLE, REQ, WAIT, XFER, GAP.
- IDLE: if `i_port_req != 0`, register the snapshot into `o_arb_data` and go to REQ.
- REQ: `o_arb_valid = 1` for exactly one cycle, then WAIT. The arbiter advances its pointer on the rising edge of valid, so a pulse never lasts longer than one cycle and is always followed by at least one low cycle.
- WAIT: on `i_arb_valid`, check `i_arb_result`:
  - one-hot: load `o_grant` and go to XFER;
  - zero or multi-hot: pulse `o_grant_err`, leave `o_grant = 0`, go to GAP;
  - no `i_arb_valid` within ARB_WAIT_CYC cycles: pulse `o_grant_err` and go to GAP.
- XFER: combinational path through the grant:
  - `o_egr_valid = |(i_port_valid & o_grant)`;
  - `o_egr_data` and `o_egr_last` come from the granted port;
  - `o_port_ready = o_grant & {10{i_egr_ready}}`; all other ports see ready 0.
- Beat accepted means `o_egr_valid & i_egr_ready`. An accepted beat with last set clears `o_grant` and goes to GAP.
- Watchdog: the counter clears on every accepted beat and increments otherwise. When it reaches TIMEOUT_CYC-1 with no accepted beat: pulse `o_timeout`, clear the grant, go to GAP.
- GAP: one cycle with all outputs idle, then IDLE. This lets the released requester drop `i_port_req`.
- A request withdrawn after the grant is issued does not cancel the grant; only last or the watchdog ends XFER.
- Outside XFER: `o_egr_valid`, `o_egr_last` and `o_port_ready` are 0, and `o_egr_data` is 0.
- Counter width is $clog2(max(TIMEOUT_CYC, ARB_WAIT_CYC)). It is shared by WAIT and XFER and cleared on each state entry.

## Timing
- Reset (`i_sys_rst_n = 0` at a clock edge): state IDLE, all outputs 0, counter 0. Reset mid-XFER drops the connection immediately with no last beat.
- Request to grant, with IDLE sampling requests at edge t:
  - `o_arb_valid` is high during cycle t+1;
  - the arbiter result is valid in cycle t+2;
  - `o_grant` is valid and XFER begins from cycle t+3.
- Egress data path has zero latency through the grant mux.
- Last beat accepted in cycle n: `o_grant = 0` at n+1 (GAP), IDLE at n+2, next `o_arb_valid` at the earliest n+3.
- If the last beat is accepted in the same cycle the watchdog expires, it counts as normal completion: no `o_timeout` pulse.
- `o_timeout` and `o_grant_err` never assert in the same cycle.

## Structure
- Shared switch-core package:
  - port-count constant `SW_PORT_NUM = 10`;
  - FSM state enum;
  - `is_onehot10` function.
- One natural sub-module, `crossbar_port_mux`: a 10:1 DATA_W+2 bit one-hot mux for data and last.

## Test plan
- Single request: `i_port_req = 10'h004`, 4-beat packet with last on beat 4, `i_egr_ready = 1` → `o_arb_valid` pulses one cycle; `o_grant = 10'h004` three cycles after the request; 4 egress beats; `o_grant = 0` the cycle after last.
- Contention: requests 0x003 held continuously → successive grants follow arbiter output (0x001, then 0x002); each `o_arb_valid` pulse separated by ≥2 low cycles.
- Backpressure: `i_egr_ready` toggling 1/0 during a 6-beat packet → `o_port_ready` tracks ready only on the granted port; exactly 6 beats accepted; data unchanged.
- Watchdog: TIMEOUT_CYC = 16, granted port sends 1 beat then stalls → `o_timeout` pulses 16 cycles after that beat; grant cleared; IDLE two cycles later.
- Bad grant: force `i_arb_result = 10'h006` with `i_arb_valid` → `o_grant_err` pulse, `o_grant` stays 0, new `o_arb_valid` issued if requests persist.
- Reset mid-XFER: assert `i_sys_rst_n = 0` during beat 2 → next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/crossbar_grant_ctrl_pkg.sv
// Shared switch-core definitions: port count, grant-controller FSM states and grant helpers.
package crossbar_grant_ctrl_pkg;

  localparam int SW_PORT_NUM = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_XFER,
    ST_GAP
  } xbar_state_e;

  function automatic logic is_onehot10(input logic [SW_PORT_NUM-1:0] v);
    return (v != '0) && ((v & (v - SW_PORT_NUM'(1))) == '0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/crossbar_grant_ctrl_if.sv
// Ingress, egress, arbiter and status signals of one egress-port grant controller.
interface crossbar_grant_ctrl_if
  import crossbar_grant_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [SW_PORT_NUM-1:0]        i_port_req;
  logic [SW_PORT_NUM*DATA_W-1:0] i_port_data;
  logic [SW_PORT_NUM-1:0]        i_port_valid;
  logic [SW_PORT_NUM-1:0]        i_port_last;
  logic [SW_PORT_NUM-1:0]        o_port_ready;

  logic [DATA_W-1:0]             o_egr_data;
  logic                          o_egr_valid;
  logic                          o_egr_last;
  logic                          i_egr_ready;

  logic [SW_PORT_NUM-1:0]        o_arb_data;
  logic                          o_arb_valid;
  logic [SW_PORT_NUM-1:0]        i_arb_result;
  logic                          i_arb_valid;

  logic [SW_PORT_NUM-1:0]        o_grant;
  logic                          o_busy;
  logic                          o_timeout;
  logic                          o_grant_err;

  modport master (
    input  i_port_req, i_port_data, i_port_valid, i_port_last, i_egr_ready,
    input  i_arb_result, i_arb_valid,
    output o_port_ready, o_egr_data, o_egr_valid, o_egr_last,
    output o_arb_data, o_arb_valid, o_grant, o_busy, o_timeout, o_grant_err
  );

  modport slave (
    output i_port_req, i_port_data, i_port_valid, i_port_last, i_egr_ready,
    output i_arb_result, i_arb_valid,
    input  o_port_ready, o_egr_data, o_egr_valid, o_egr_last,
    input  o_arb_data, o_arb_valid, o_grant, o_busy, o_timeout, o_grant_err
  );

endinterface

// File: rtl/crossbar_port_mux.sv
// One-hot AND-OR selector over the ten ingress lanes; zero select yields zero.
module crossbar_port_mux
  import crossbar_grant_ctrl_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [SW_PORT_NUM-1:0]   i_sel,
  input  logic [SW_PORT_NUM*W-1:0] i_dat,
  output logic [W-1:0]             o_dat
);

  always_comb begin
    o_dat = '0;
    for (int k = 0; k < SW_PORT_NUM; k++) begin
      o_dat = o_dat | (i_dat[k*W +: W] & {W{i_sel[k]}});
    end
  end

endmodule

// File: rtl/crossbar_grant_ctrl.sv
// Egress-port grant controller: snapshots requests, runs one arbitration round, then
// holds the one-hot crossbar connection until last beat, watchdog expiry or reset.
module crossbar_grant_ctrl
  import crossbar_grant_ctrl_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int ARB_WAIT_CYC = 4
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  crossbar_grant_ctrl_if.master io_xbar
);

  localparam int CNT_MAX = max_int(TIMEOUT_CYC, ARB_WAIT_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int MUX_W   = DATA_W + 2;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ARB_LAST = CNT_W'(ARB_WAIT_CYC - 1);

  xbar_state_e             r_state;
  xbar_state_e             w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [SW_PORT_NUM-1:0]  r_grant;
  logic [SW_PORT_NUM-1:0]  w_grant_nxt;
  logic [SW_PORT_NUM-1:0]  r_arb_data;
  logic [SW_PORT_NUM-1:0]  w_arb_data_nxt;

  logic [SW_PORT_NUM*MUX_W-1:0] w_mux_in;
  logic [MUX_W-1:0]             w_mux_out;
  logic                         w_xfer;
  logic                         w_egr_valid;
  logic                         w_egr_last;
  logic                         w_accept;
  logic                         w_timeout;
  logic                         w_grant_err;

  // Each lane carries {valid, last, data} so one mux serves the whole beat.
  always_comb begin
    w_mux_in = '0;
    for (int k = 0; k < SW_PORT_NUM; k++) begin
      w_mux_in[k*MUX_W +: MUX_W] = {io_xbar.i_port_valid[k], io_xbar.i_port_last[k],
                                    io_xbar.i_port_data[k*DATA_W +: DATA_W]};
    end
  end

  crossbar_port_mux #(
    .W (MUX_W)
  ) u_port_mux (
    .i_sel (r_grant),
    .i_dat (w_mux_in),
    .o_dat (w_mux_out)
  );

  assign w_xfer      = (r_state == ST_XFER);
  assign w_egr_valid = w_xfer & w_mux_out[MUX_W-1];
  assign w_egr_last  = w_xfer & w_mux_out[MUX_W-2];
  assign w_accept    = w_egr_valid & io_xbar.i_egr_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_arb_data_nxt = r_arb_data;
    w_cnt_nxt      = '0;
    w_timeout      = 1'b0;
    w_grant_err    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|io_xbar.i_port_req) begin
          w_arb_data_nxt = io_xbar.i_port_req;
          w_state_nxt    = ST_REQ;
        end
      end
      ST_REQ: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (io_xbar.i_arb_valid) begin
          w_arb_data_nxt = '0;
          if (is_onehot10(io_xbar.i_arb_result)) begin
            w_grant_nxt = io_xbar.i_arb_result;
            w_state_nxt = ST_XFER;
          end else begin
            w_grant_err = 1'b1;
            w_state_nxt = ST_GAP;
          end
        end else if (r_cnt == ARB_LAST) begin
          w_arb_data_nxt = '0;
          w_grant_err    = 1'b1;
          w_state_nxt    = ST_GAP;
        end
      end
      ST_XFER: begin
        w_cnt_nxt = w_accept ? '0 : r_cnt + CNT_W'(1);
        // A last beat landing on the expiry cycle is a normal completion.
        if (w_accept && w_egr_last) begin
          w_grant_nxt = '0;
          w_state_nxt = ST_GAP;
        end else if (!w_accept && (r_cnt == TO_LAST)) begin
          w_timeout   = 1'b1;
          w_grant_nxt = '0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_arb_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_arb_data <= w_arb_data_nxt;
    end
  end

  assign io_xbar.o_port_ready = w_xfer ? (r_grant & {SW_PORT_NUM{io_xbar.i_egr_ready}}) : '0;
  assign io_xbar.o_egr_data   = w_xfer ? w_mux_out[DATA_W-1:0] : '0;
  assign io_xbar.o_egr_valid  = w_egr_valid;
  assign io_xbar.o_egr_last   = w_egr_last;
  assign io_xbar.o_arb_data   = r_arb_data;
  assign io_xbar.o_arb_valid  = (r_state == ST_REQ);
  assign io_xbar.o_grant      = r_grant;
  assign io_xbar.o_busy       = (r_state != ST_IDLE);
  assign io_xbar.o_timeout    = w_timeout;
  assign io_xbar.o_grant_err  = w_grant_err;

endmodule

// File: tb/tb_crossbar_grant_ctrl.sv
// Randomized bench for crossbar_grant_ctrl: the bench plays arbiter and ingress sources
// and predicts every output per cycle from the request/grant/transfer timing rules.
module tb_crossbar_grant_ctrl;
  import crossbar_grant_ctrl_pkg::*;

  localparam int DATA_W = 8;
  localparam int TO     = 16;
  localparam int AW     = 4;
  localparam int N      = SW_PORT_NUM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crossbar_grant_ctrl_if #(.DATA_W(DATA_W)) xb ();

  crossbar_grant_ctrl #(
    .DATA_W       (DATA_W),
    .TIMEOUT_CYC  (TO),
    .ARB_WAIT_CYC (AW)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .io_xbar     (xb)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_arb = -100;
  int obs_acc = 0;

  logic              e_arb_valid, e_arb_chk, e_busy, e_timeout, e_err;
  logic              e_egr_valid, e_egr_last;
  logic [N-1:0]      e_arb_data, e_grant, e_ready;
  logic [DATA_W-1:0] e_egr_data;

  logic [DATA_W-1:0] d_data [N];
  logic [N-1:0]      d_valid, d_last;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_quiet(input logic busy);
    e_arb_valid = 1'b0; e_arb_chk = 1'b0; e_arb_data = '0; e_busy = busy;
    e_timeout = 1'b0; e_err = 1'b0; e_grant = '0; e_ready = '0;
    e_egr_valid = 1'b0; e_egr_last = 1'b0; e_egr_data = '0;
  endtask

  task automatic junk_ports();
    for (int k = 0; k < N; k++) d_data[k] = DATA_W'($urandom);
    d_valid = N'($urandom);
    d_last  = N'($urandom);
    xb.i_port_req  = N'($urandom);
    xb.i_egr_ready = 1'($urandom);
  endtask

  // Applies stimulus, checks every output 1ns later, then moves to the next negedge.
  task automatic cycle();
    for (int k = 0; k < N; k++) xb.i_port_data[k*DATA_W +: DATA_W] = d_data[k];
    xb.i_port_valid = d_valid;
    xb.i_port_last  = d_last;
    #1;
    check_eq("arb_valid", 32'(xb.o_arb_valid), 32'(e_arb_valid));
    if (e_arb_chk) check_eq("arb_data", 32'(xb.o_arb_data), 32'(e_arb_data));
    check_eq("grant", 32'(xb.o_grant), 32'(e_grant));
    check_eq("busy", 32'(xb.o_busy), 32'(e_busy));
    check_eq("timeout", 32'(xb.o_timeout), 32'(e_timeout));
    check_eq("grant_err", 32'(xb.o_grant_err), 32'(e_err));
    check_eq("egr_valid", 32'(xb.o_egr_valid), 32'(e_egr_valid));
    check_eq("egr_last", 32'(xb.o_egr_last), 32'(e_egr_last));
    check_eq("egr_data", 32'(xb.o_egr_data), 32'(e_egr_data));
    check_eq("port_ready", 32'(xb.o_port_ready), 32'(e_ready));
    if (xb.o_arb_valid === 1'b1) begin
      check_eq("arb_pulse_spacing", 32'((cyc - last_arb) >= 3), 32'd1);
      last_arb = cyc;
    end
    if (xb.o_egr_valid === 1'b1 && xb.i_egr_ready === 1'b1) obs_acc++;
    cyc++;
    @(negedge clk);
  endtask

  // mode: 0 random ready with source bubbles, 1 ready held high, 2 ready toggling 1/0.
  task automatic episode(input logic [N-1:0] req, input logic respond, input logic [N-1:0] res,
                         input int len, input int mode, input int stall_after,
                         input int pre_stall, input int rst_beat);
    int p, idx, since, held, nacc, acc0;
    logic rdy, acc, fin;
    logic [DATA_W-1:0] pkt [$];
    junk_ports(); xb.i_port_req = req;
    expect_quiet(1'b0); cycle();
    junk_ports(); expect_quiet(1'b1);
    e_arb_valid = 1'b1; e_arb_chk = 1'b1; e_arb_data = req; cycle();
    if (!respond) begin
      for (int k = 0; k < AW; k++) begin
        junk_ports(); expect_quiet(1'b1); e_err = (k == AW - 1); cycle();
      end
    end else begin
      junk_ports(); xb.i_arb_valid = 1'b1; xb.i_arb_result = res;
      expect_quiet(1'b1); e_err = ($countones(res) != 1); cycle();
      xb.i_arb_valid = 1'b0; xb.i_arb_result = '0;
    end
    if (!respond || $countones(res) != 1) begin
      junk_ports(); expect_quiet(1'b1); cycle();
      return;
    end
    p = 0;
    for (int k = 0; k < N; k++) if (res[k]) p = k;
    pkt.delete();
    for (int b = 0; b < len; b++) pkt.push_back(DATA_W'($urandom));
    idx = 0; since = 0; held = 0; nacc = 0; fin = 1'b0; acc0 = obs_acc;
    while (!fin) begin
      junk_ports();
      d_data[p]  = pkt[idx];
      d_last[p]  = (idx == len - 1);
      d_valid[p] = (held >= pre_stall) && (idx < stall_after) &&
                   (mode != 0 || $urandom_range(3) != 0);
      rdy = (mode == 1) ? 1'b1 : (mode == 2) ? (held % 2 == 0) : 1'($urandom);
      xb.i_egr_ready = rdy;
      acc = d_valid[p] && rdy;
      expect_quiet(1'b1);
      e_grant = res; e_egr_valid = d_valid[p]; e_egr_data = d_data[p];
      e_egr_last = d_last[p]; e_ready = res & {N{rdy}};
      e_timeout = !acc && (since == TO - 1);
      if (rst_beat > 0 && idx == rst_beat - 1) begin
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; junk_ports(); xb.i_port_req = '0;
        expect_quiet(1'b0); e_arb_chk = 1'b1; cycle();
        return;
      end
      cycle();
      held++;
      if (acc) begin
        nacc++; since = 0;
        if (idx == len - 1) fin = 1'b1;
        idx++;
      end else if (since == TO - 1) begin
        fin = 1'b1;
      end else begin
        since++;
      end
    end
    check_eq("accepted_beats", 32'(obs_acc - acc0), 32'(nacc));
    junk_ports(); expect_quiet(1'b1); cycle();
  endtask

  initial begin
    logic [N-1:0] req, res;
    int bits [$];
    xb.i_arb_valid = 1'b0; xb.i_arb_result = '0;
    junk_ports();
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      junk_ports(); expect_quiet(1'b0); e_arb_chk = 1'b1;
      if (k == 2) begin rst_n = 1'b1; xb.i_port_req = '0; end
      cycle();
    end

    episode(10'h004, 1'b1, 10'h004, 4, 1, 99, 0, 0);
    episode(10'h003, 1'b1, 10'h001, 3, 1, 99, 0, 0);
    episode(10'h003, 1'b1, 10'h002, 2, 1, 99, 0, 0);
    episode(10'h021, 1'b1, 10'h020, 6, 2, 99, 0, 0);
    episode(10'h080, 1'b1, 10'h080, 4, 1, 1, 0, 0);
    episode(10'h006, 1'b1, 10'h006, 1, 1, 99, 0, 0);
    episode(10'h006, 1'b1, 10'h002, 2, 1, 99, 0, 0);
    episode(10'h100, 1'b1, 10'h000, 1, 1, 99, 0, 0);
    episode(10'h200, 1'b0, 10'h000, 1, 1, 99, 0, 0);
    episode(10'h001, 1'b1, 10'h001, 1, 1, 99, TO - 1, 0);
    episode(10'h008, 1'b1, 10'h008, 1, 1, 99, TO, 0);
    episode(10'h010, 1'b1, 10'h010, 5, 1, 99, 0, 2);

    for (int e = 0; e < 70; e++) begin
      int kind;
      for (int g = $urandom_range(2); g > 0; g--) begin
        junk_ports(); xb.i_port_req = '0; expect_quiet(1'b0); cycle();
      end
      req = N'($urandom_range(1023, 1));
      bits.delete();
      for (int k = 0; k < N; k++) if (req[k]) bits.push_back(k);
      res = '0;
      res[bits[$urandom_range(bits.size() - 1)]] = 1'b1;
      kind = $urandom_range(9);
      if (kind == 7) begin
        res = N'($urandom);
        if ($countones(res) == 1) res = '0;
      end
      episode(req, kind != 8, res, $urandom_range(8, 1), $urandom_range(2),
              (kind == 6) ? $urandom_range(3) : 99,
              (kind == 5) ? $urandom_range(TO) : 0,
              (kind == 4 && $urandom_range(2) == 0) ? $urandom_range(3, 1) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
